mem_req_arbiter: RTL and testbench

Arbitrates the instruction-fetch and data-access SRAM-like master ports onto one shared SRAM-like memory port. It sits between the pipeline (IF stage requests, EX/MEM stage requests) and the single memory/bridge interface. It tracks up to DEPTH outstanding accepted requests in order, and routes each returned data_ok/rdata back to the master that issued it.

---
 rtl/mem_req_arbiter.sv | 94 +++++++++
 tb/tb_mem_req_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like port between inst and data masters, routing in-order responses via a tag FIFO.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with data winning.
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, GNT_INST, GNT_DATA} state_t;
  state_t state_q, state_d;
  logic [PW:0] cnt_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [DEPTH-1:0] tag_q;
  logic sel_i, sel_d, full, empty, push, pop, head, pick_data;
`ifdef ARB_RR_EN
  logic last_q;
  assign pick_data = data_req & (~inst_req | ~last_q);
  always_ff @(posedge clk)
    if (reset) last_q <= 1'b0;
    else if (push) last_q <= sel_d;
`else
  assign pick_data = data_req;
`endif
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = tag_q[rptr_q];
  always_comb begin
    sel_i        = state_q == GNT_INST;
    sel_d        = state_q == GNT_DATA;
    mem_req      = (sel_i & inst_req) | (sel_d & data_req);
    mem_wr       = sel_i ? inst_wr    : sel_d ? data_wr    : 1'b0;
    mem_size     = sel_i ? inst_size  : sel_d ? data_size  : '0;
    mem_addr     = sel_i ? inst_addr  : sel_d ? data_addr  : '0;
    mem_wstrb    = sel_i ? inst_wstrb : sel_d ? data_wstrb : '0;
    mem_wdata    = sel_i ? inst_wdata : sel_d ? data_wdata : '0;
    inst_addr_ok = sel_i & mem_addr_ok;
    data_addr_ok = sel_d & mem_addr_ok;
    push         = mem_req & mem_addr_ok;
    pop          = mem_data_ok & ~empty;
    inst_data_ok = pop & ~head;
    data_data_ok = pop & head;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    // A dropped request in a grant state abandons the grant without pushing.
    state_d      = state_q == IDLE
                   ? ((!full && (inst_req || data_req)) ? (pick_data ? GNT_DATA : GNT_INST) : IDLE)
                   : ((!mem_req || mem_addr_ok) ? IDLE : state_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      wptr_q  <= wptr_q + PW'(push);
      rptr_q  <= rptr_q + PW'(pop);
      if (push) tag_q[wptr_q] <= sel_d;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed stimulus with a grant/response scoreboard checked by a negedge monitor.
module tb_mem_req_arbiter;
  logic clk = 0, reset = 1;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 0, data_size = 0, mem_size;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic [3:0] inst_wstrb = 0, data_wstrb = 0, mem_wstrb;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic mem_req, mem_wr;
  logic mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  int total = 0, bad = 0;
  logic exp_gnt[$];
  logic [32:0] exp_rsp[$];

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inst_addr_ok || data_addr_ok) begin
      total++;
      if (exp_gnt.size() == 0) begin
        bad++;
        $display("FAIL gnt_unexpected: got inst=%0b data=%0b, required none", inst_addr_ok, data_addr_ok);
      end else begin
        logic e;
        e = exp_gnt.pop_front();
        if (data_addr_ok != e || (inst_addr_ok && data_addr_ok)) begin
          bad++;
          $display("FAIL gnt_order: got inst=%0b data=%0b, required data=%0b", inst_addr_ok, data_addr_ok, e);
        end
      end
    end
    if (inst_data_ok || data_data_ok) begin
      total++;
      if (exp_rsp.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got inst=%0b data=%0b, required none", inst_data_ok, data_data_ok);
      end else begin
        logic [32:0] e, g;
        e = exp_rsp.pop_front();
        g = {data_data_ok, data_data_ok ? data_rdata : inst_rdata};
        if (g != e || (inst_data_ok && data_data_ok)) begin
          bad++;
          $display("FAIL rsp_route: got %h (both=%0b), required %h", g, inst_data_ok && data_data_ok, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic m, input logic r, input logic [31:0] a, input logic w, input logic [31:0] wd);
    if (m) begin
      data_req = r; data_addr = a; data_wr = w; data_wdata = wd; data_wstrb = w ? 4'hf : 4'h0; data_size = r ? 2'd2 : 2'd0;
    end else begin
      inst_req = r; inst_addr = a; inst_wr = w; inst_wdata = wd; inst_wstrb = w ? 4'hf : 4'h0; inst_size = r ? 2'd2 : 2'd0;
    end
  endtask

  task automatic issue(input logic m, input logic [31:0] a, input logic w, input logic [31:0] wd);
    int n = 0;
    exp_gnt.push_back(m);
    drive(m, 1'b1, a, w, wd);
    do begin step(); n++; end while (!(m ? data_addr_ok : inst_addr_ok) && n < 20);
    chk("accept_in_time", 32'(n < 20), 32'd1);
    chk("mem_addr", mem_addr, a);
    chk("mem_wr", 32'(mem_wr), 32'(w));
    chk("mem_wdata", mem_wdata, wd);
    chk("mem_size", 32'(mem_size), 32'd2);
    step();
    drive(m, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic respond(input logic m, input logic [31:0] d);
    exp_rsp.push_back({m, d});
    mem_data_ok = 1; mem_rdata = d;
    step();
    mem_data_ok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    reset = 0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    mem_addr_ok = 1;
    // single data read
    issue(1'b1, 32'h1000, 1'b0, 32'd0);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    step();
    respond(1'b1, 32'hDEADBEEF);
    // spurious response with empty FIFO
    mem_data_ok = 1; mem_rdata = 32'h99;
    step();
    chk("spurious_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    // simultaneous requests, responses returned every cycle
    drive(1'b0, 1'b1, 32'h2000, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 32'h3000, 1'b1, 32'hCAFE0000);
    mem_rdata = 32'h55;
`ifdef ARB_RR_EN
    foreach (exp_gnt[i]) ;
    exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b0);
    exp_rsp.push_back({1'b1, 32'h55}); exp_rsp.push_back({1'b0, 32'h55});
    exp_rsp.push_back({1'b1, 32'h55}); exp_rsp.push_back({1'b0, 32'h55});
`else
    repeat (4) begin exp_gnt.push_back(1'b1); exp_rsp.push_back({1'b1, 32'h55}); end
`endif
    step();
    chk("sim_first_mem_addr", mem_addr, 32'h3000);
    chk("sim_first_mem_wr", 32'(mem_wr), 32'd1);
    repeat (7) step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    mem_data_ok = 0;
    step();
    chk("sim_gnt_drained", exp_gnt.size(), 32'd0);
    chk("sim_rsp_drained", exp_rsp.size(), 32'd0);
    // full FIFO stalls a third request
    issue(1'b0, 32'h4000, 1'b0, 32'd0);
    issue(1'b1, 32'h5000, 1'b1, 32'h12345678);
    exp_gnt.push_back(1'b0);
    drive(1'b0, 1'b1, 32'h6000, 1'b0, 32'd0);
    step(); chk("full_no_req0", 32'(mem_req), 32'd0);
    step(); chk("full_no_req1", 32'(mem_req), 32'd0);
    exp_rsp.push_back({1'b0, 32'h11});
    mem_data_ok = 1; mem_rdata = 32'h11;
    chk("pop_cycle_no_req", 32'(mem_req), 32'd0);
    step();
    mem_data_ok = 0;
    chk("after_pop_no_req", 32'(mem_req), 32'd0);
    step();
    chk("req_two_after_pop", 32'(mem_req), 32'd1);
    chk("req_addr_after_pop", mem_addr, 32'h6000);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    // in-order return: data then inst
    respond(1'b1, 32'h22);
    respond(1'b0, 32'h33);
    // push and pop in the same cycle keeps one entry
    issue(1'b0, 32'h7000, 1'b0, 32'd0);
    exp_gnt.push_back(1'b1);
    drive(1'b1, 1'b1, 32'h8000, 1'b0, 32'd0);
    step();
    exp_rsp.push_back({1'b0, 32'h44});
    mem_data_ok = 1; mem_rdata = 32'h44;
    step();
    mem_data_ok = 0;
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    respond(1'b1, 32'h66);
    mem_data_ok = 1;
    step();
    chk("count_was_one", 32'({inst_data_ok, data_data_ok}), 32'd0);
    mem_data_ok = 0;
    // reset mid-grant with one response outstanding
    issue(1'b1, 32'h9000, 1'b0, 32'd0);
    mem_addr_ok = 0;
    drive(1'b0, 1'b1, 32'hA000, 1'b0, 32'd0);
    step();
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    reset = 1;
    step();
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    reset = 0;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    mem_data_ok = 1; mem_rdata = 32'h77;
    step();
    chk("rst_dropped_rsp", 32'({inst_data_ok, data_data_ok}), 32'd0);
    mem_data_ok = 0;
    step();
    chk("end_gnt_q", exp_gnt.size(), 32'd0);
    chk("end_rsp_q", exp_rsp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
